uart_tx_fifo: RTL and testbench

//   Buffered UART transmitter (8N1) that drives the serial line into the core's rx input.

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int BW    = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic               r_overflow;

  state_t             r_state;
  logic [7:0]         r_shift;
  logic [2:0]         r_bit_idx;
  logic [BW-1:0]      r_baud;
  logic               r_tx;
`ifdef UART_TX_PARITY_EN
  logic               r_parity;
`endif

  state_t             w_state_nxt;
  logic [7:0]         w_shift_nxt;
  logic [2:0]         w_bit_nxt;
  logic [BW-1:0]      w_baud_nxt;
  logic               w_tx_nxt;
  logic               w_pop;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic               w_baud_last;
  logic [7:0]         w_head;

  assign w_full      = (r_count == (FIFO_AW+1)'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = wr_en && !w_full;
  assign w_baud_last = (r_baud == BW'(CLKS_PER_BIT - 1));
  assign w_head      = r_mem[r_rd_ptr];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_idx;
    w_baud_nxt  = '0;
    w_pop       = 1'b0;
    w_tx_nxt    = 1'b1;

    if (r_state != S_IDLE) w_baud_nxt = w_baud_last ? '0 : r_baud + 1'b1;

    unique case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_state_nxt = S_DATA;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_shift_nxt = r_shift >> 1;
          w_bit_nxt   = r_bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
          if (r_bit_idx == 3'd7) w_state_nxt = S_PARITY;
`else
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_last) w_state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        // Chain straight into the next frame so there is no idle gap.
        if (w_baud_last) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // tx is registered, so it is decoded from the state being entered.
    unique case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = r_parity;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_baud    <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_nxt;
      r_baud    <= w_baud_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst)        r_parity <= 1'b0;
    else if (w_pop) r_parity <= ^w_head;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign busy     = (r_state != S_IDLE);
  assign overflow = r_overflow;
  assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4, FIFO_AW=2).
// Outputs are sampled on falling edges or 1 ns after a rising edge.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int AW  = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din   = 8'h00;
  logic       full, empty, busy, overflow, tx;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .wr_en    (wr_en),
    .full     (full),
    .empty    (empty),
    .busy     (busy),
    .overflow (overflow),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected line level for a slot of the frame: start, 8 data LSB-first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks tx on each cycle of a frame from cycle index 'first'; the next falling edge
  // must be that cycle.
  task automatic check_frame(input logic [7:0] b, input int first);
    int busy_low;
    busy_low = 0;
    for (int i = first; i < NSLOT*CPB; i++) begin
      @(negedge clk);
      check($sformatf("tx_%02h_c%0d", b, i), 32'(tx), 32'(exp_bit(b, i / CPB)));
      if (!busy) busy_low++;
    end
    check($sformatf("busy_in_frame_%02h", b), busy_low, 0);
  endtask

  // Writes n bytes on consecutive edges; returns 1 ns after the last accepting edge.
  task automatic write_burst(input logic [7:0] data [8], input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      din   = data[i];
      wr_en = 1'b1;
    end
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  initial begin
    int bad;

    // 1: reset and idle line
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx",       32'(tx),       32'd1);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_50_cycles", bad, 0);

    // 2: single byte 0x55, tx low from edge k+1, busy falls at edge k+41
    write_burst('{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
    @(negedge clk);
    check("pre_start_tx",    32'(tx),    32'd1);
    check("pre_start_empty", 32'(empty), 32'd0);
    check_frame(8'h55, 0);
    @(negedge clk);
    check("single_busy_fall", 32'(busy),  32'd0);
    check("single_tx_idle",   32'(tx),    32'd1);
    check("single_empty",     32'(empty), 32'd1);
    repeat (5) @(negedge clk);

    // 3: back-to-back frames with no gap, 80 cycles total
    write_burst('{8'hA3, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
    check_frame(8'hA3, 0);
    check_frame(8'h0F, 0);
    @(negedge clk);
    check("b2b_busy_fall", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);

    // 4: fill while busy, 0x06 dropped, overflow sticky
    write_burst('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00}, 6);
    check("ovf_full",     32'(full),     32'd1);
    check("ovf_overflow", 32'(overflow), 32'd1);
    check("ovf_empty",    32'(empty),    32'd0);
    check_frame(8'h01, 4);
    for (int b = 2; b <= 5; b++) check_frame(8'(b), 0);
    @(negedge clk);
    check("ovf_done_busy",     32'(busy),     32'd0);
    check("ovf_done_empty",    32'(empty),    32'd1);
    check("ovf_done_full",     32'(full),     32'd0);
    check("ovf_sticky",        32'(overflow), 32'd1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("ovf_no_sixth_frame", bad, 0);

    // 5: reset during 3rd data bit of 0xFF with two bytes queued
    write_burst('{8'hFF, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
    repeat (12) @(negedge clk);
    check("mid_busy",  32'(busy),  32'd1);
    check("mid_empty", 32'(empty), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_tx",       32'(tx),       32'd1);
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_empty",    32'(empty),    32'd1);
    check("abort_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("abort_no_frames", bad, 0);

`ifdef UART_TX_PARITY_EN
    // 6: even parity of 0x07 is 1, frame is 44 cycles
    write_burst('{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1);
    @(negedge clk);
    check("par_pre_start", 32'(tx), 32'd1);
    check_frame(8'h07, 0);
    @(negedge clk);
    check("par_busy_fall", 32'(busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
